sensor_hcsr04_emulador: RTL and testbench
=========================================

SENSOR_HCSR04_EMULADOR -- requirements
Module: sensor_hcsr04_emulador

Interface
REQ-001 Parameter TRIG_MIN, default 500, is the minimum accepted trigger width in clocks (10 us at 50 MHz).
REQ-002 Parameter ECO_ATRASO, default 10000, is the number of clocks from trigger acceptance to echo rise (200 us).
REQ-003 Parameter CLK_POR_MM, default 294, is the echo width in clocks per mm of distance.
REQ-004 Parameter MAX_MM, default 4000, is the largest distance in mm that produces a proportional echo.
REQ-005 Parameter TIMEOUT, default 1900000, is the echo width in clocks for out-of-range distance (38 ms).
REQ-006 Parameter RECUPERA, default 50000, is the holdoff in clocks after echo fall before a new trigger is accepted.
REQ-007 clock  in  1  single system clock; all state changes on the rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 habilita  in  1  enables trigger acceptance.
REQ-010 trigger  in  1  asynchronous trigger from the measuring interface.
REQ-011 distancia  in  12  unsigned binary distance in mm to emulate.
REQ-012 echo  out  1  registered echo pulse.
REQ-013 ocupado  out  1  high in states ESPERA, ECO and RECUPERA.
REQ-014 erro_trigger  out  1  one-cycle pulse when a trigger is rejected as too short.
REQ-015 db_estado  out  3  current state code.

Function
REQ-016 trigger SHALL pass through a 2-flop synchronizer; "trig_s" below denotes the synchronized value (2-clock latency).
REQ-017 States and codes SHALL be INICIAL=0, MEDE=1, ESPERA=2, ECO=3 and RECUPERA=4.
REQ-018 State INICIAL SHALL go to MEDE when trig_s=1 and habilita=1; otherwise it SHALL stay in INICIAL.
REQ-019 State MEDE SHALL count clocks while trig_s=1, using a counter that saturates at TRIG_MIN.
REQ-020 In MEDE, on trig_s=0 with count>=TRIG_MIN, the block SHALL go to ESPERA and latch distancia in the same cycle.
REQ-021 In MEDE, on trig_s=0 with count<TRIG_MIN, the block SHALL return to INICIAL and pulse erro_trigger for exactly 1 cycle.
REQ-022 The latched echo width W SHALL equal distancia*CLK_POR_MM if 1<=distancia<=MAX_MM, else TIMEOUT.
REQ-023 W SHALL be held in a 21-bit unsigned register, with no overflow for any legal parameter set.
REQ-024 ESPERA SHALL last exactly ECO_ATRASO cycles and then go to ECO.
REQ-025 echo SHALL be 1 in exactly the W consecutive cycles of ECO and 0 in every other cycle.
REQ-026 After ECO the block SHALL go to RECUPERA, which lasts exactly RECUPERA cycles, then return to INICIAL.
REQ-027 trigger activity in ESPERA, ECO or RECUPERA SHALL be ignored, with no restart, no re-latch and no erro_trigger.
REQ-028 A trigger still high on return to INICIAL SHALL be treated as a new trigger.
REQ-029 A habilita change SHALL only be sampled in INICIAL; an operation already in progress SHALL complete.
REQ-030 A distancia change after the latch SHALL NOT affect the current echo.
REQ-031 The trigger-acceptance-to-echo-rise latency SHALL be ECO_ATRASO+1 clocks, fixed.

Reset
REQ-032 While reset=0 the block SHALL be in state INICIAL.
REQ-033 While reset=0 outputs SHALL be echo=0, ocupado=0, erro_trigger=0 and db_estado=0.
REQ-034 While reset=0 all counters, synchronizer flops and W SHALL be 0.
REQ-035 Assertion of reset SHALL clear all state immediately (asynchronous); release SHALL take effect at the next rising edge.
REQ-036 Reset asserted mid-echo SHALL drop echo in the same instant, with no completion of the pulse.

Verification
REQ-037 Trigger 600 clk high, distancia=100, habilita=1 -> echo rises ECO_ATRASO+1 clk after trig_s falls, high exactly 29400 clk, ocupado high through RECUPERA.
REQ-038 Trigger 400 clk high -> erro_trigger high exactly 1 clk, echo stays 0, db_estado returns to 0.
REQ-039 distancia=0, then separately distancia=4001 -> echo high exactly 1900000 clk each time.
REQ-040 Second trigger pulsed during ECO, and distancia changed during ECO -> echo width unchanged (29400) and no second echo until RECUPERA ends.
REQ-041 reset=0 for 3 clk midway through ECO -> echo=0 and db_estado=0 immediately, then a normal cycle after release.
REQ-042 habilita=0 with trigger 600 clk -> no state change and echo stays 0; habilita=1 with trigger still high -> normal measurement.

Source files
------------

// File: rtl/sensor_hcsr04_emulador_if.sv
// Signal bundle between a measuring interface (master) and the HC-SR04
// ultrasonic sensor emulator (slave).
interface sensor_hcsr04_emulador_if;
    logic        habilita;
    logic        trigger;
    logic [11:0] distancia;
    logic        echo;
    logic        ocupado;
    logic        erro_trigger;
    logic [2:0]  db_estado;

    modport master (
        output habilita, trigger, distancia,
        input  echo, ocupado, erro_trigger, db_estado
    );

    modport slave (
        input  habilita, trigger, distancia,
        output echo, ocupado, erro_trigger, db_estado
    );
endinterface

// File: rtl/sensor_hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor emulator: validates the trigger width, waits a
// fixed delay, then produces an echo pulse whose width is proportional to the
// latched distance (or a timeout width when out of range), followed by a
// recovery holdoff. ECO_ATRASO and RECUPERA are expected to be at least 1.
module sensor_hcsr04_emulador #(
    parameter int unsigned TRIG_MIN   = 500,
    parameter int unsigned ECO_ATRASO = 10000,
    parameter int unsigned CLK_POR_MM = 294,
    parameter int unsigned MAX_MM     = 4000,
    parameter int unsigned TIMEOUT    = 1900000,
    parameter int unsigned RECUPERA   = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    sensor_hcsr04_emulador_if.slave       bus
);

    localparam logic [2:0] S_INICIAL  = 3'd0;
    localparam logic [2:0] S_MEDE     = 3'd1;
    localparam logic [2:0] S_ESPERA   = 3'd2;
    localparam logic [2:0] S_ECO      = 3'd3;
    localparam logic [2:0] S_RECUPERA = 3'd4;

    // Trigger counter only needs to reach TRIG_MIN, where it saturates.
    localparam int TW = (TRIG_MIN < 2) ? 1 : $clog2(TRIG_MIN + 1);

    logic           trig_meta;
    logic           trig_s;
    logic [2:0]     estado;
    logic [TW-1:0]  cont_trig;
    logic [20:0]    cont;
    logic [20:0]    largura;
    logic           echo_r;
    logic           erro_r;
    logic [31:0]    produto;
    logic [20:0]    largura_calc;

    // Echo width for the current distancia; zero or beyond MAX_MM maps to TIMEOUT.
    always_comb begin
        produto = 32'(bus.distancia) * CLK_POR_MM;
        if (bus.distancia != 12'd0 && 32'(bus.distancia) <= MAX_MM)
            largura_calc = produto[20:0];
        else
            largura_calc = 21'(TIMEOUT);
    end

    // Two-flop synchronizer for the asynchronous trigger input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
        end else begin
            trig_meta <= bus.trigger;
            trig_s    <= trig_meta;
        end
    end

    // Main FSM: trigger qualification, delay, echo generation and holdoff.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= S_INICIAL;
            cont_trig <= '0;
            cont      <= '0;
            largura   <= '0;
            echo_r    <= 1'b0;
            erro_r    <= 1'b0;
        end else begin
            erro_r <= 1'b0;
            case (estado)
                S_INICIAL: begin
                    // The cycle that starts the measurement counts as the first high cycle.
                    if (trig_s && bus.habilita) begin
                        estado    <= S_MEDE;
                        cont_trig <= TW'(1);
                    end
                end
                S_MEDE: begin
                    if (trig_s) begin
                        if (cont_trig < TW'(TRIG_MIN))
                            cont_trig <= cont_trig + TW'(1);
                    end else if (cont_trig >= TW'(TRIG_MIN)) begin
                        estado    <= S_ESPERA;
                        largura   <= largura_calc;
                        cont      <= '0;
                        cont_trig <= '0;
                    end else begin
                        estado    <= S_INICIAL;
                        erro_r    <= 1'b1;
                        cont_trig <= '0;
                    end
                end
                S_ESPERA: begin
                    if (cont == 21'(ECO_ATRASO - 1)) begin
                        estado <= S_ECO;
                        echo_r <= 1'b1;
                        cont   <= '0;
                    end else begin
                        cont <= cont + 21'd1;
                    end
                end
                S_ECO: begin
                    if (cont == largura - 21'd1) begin
                        estado <= S_RECUPERA;
                        echo_r <= 1'b0;
                        cont   <= '0;
                    end else begin
                        cont <= cont + 21'd1;
                    end
                end
                S_RECUPERA: begin
                    if (cont == 21'(RECUPERA - 1)) begin
                        estado <= S_INICIAL;
                        cont   <= '0;
                    end else begin
                        cont <= cont + 21'd1;
                    end
                end
                default: begin
                    estado <= S_INICIAL;
                    echo_r <= 1'b0;
                    cont   <= '0;
                end
            endcase
        end
    end

    assign bus.echo         = echo_r;
    assign bus.erro_trigger = erro_r;
    assign bus.db_estado    = estado;
    assign bus.ocupado      = (estado == S_ESPERA) || (estado == S_ECO) ||
                              (estado == S_RECUPERA);

endmodule

// File: tb/tb_sensor_hcsr04_emulador.sv
// Directed bench for the HC-SR04 emulator using scaled-down timing parameters.
module tb_sensor_hcsr04_emulador;

    localparam int TRIG_MIN   = 5;
    localparam int ECO_ATRASO = 10;
    localparam int CLK_POR_MM = 3;
    localparam int MAX_MM     = 20;
    localparam int TIMEOUT    = 100;
    localparam int RECUPERA   = 15;
    // Trigger fall to echo rise seen by the bench: 2 sync flops + ECO_ATRASO + 1.
    localparam int LATENCIA   = ECO_ATRASO + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sensor_hcsr04_emulador_if bus();

    sensor_hcsr04_emulador #(
        .TRIG_MIN(TRIG_MIN), .ECO_ATRASO(ECO_ATRASO), .CLK_POR_MM(CLK_POR_MM),
        .MAX_MM(MAX_MM), .TIMEOUT(TIMEOUT), .RECUPERA(RECUPERA)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop_cyc = 0;

    // Monitor state (sampled on the falling edge).
    logic echo_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   rise_cyc = 0;
    int   cur_w = 0;
    int   last_w = 0;
    int   pulses = 0;
    int   busy_cur = 0;
    int   last_busy = 0;
    int   erro_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        echo_prev <= bus.echo;
        busy_prev <= bus.ocupado;
        if (bus.echo && !echo_prev) begin
            rise_cyc <= cyc;
            cur_w    <= 1;
        end else if (bus.echo) begin
            cur_w <= cur_w + 1;
        end
        if (!bus.echo && echo_prev) begin
            last_w <= cur_w;
            pulses <= pulses + 1;
        end
        if (bus.ocupado && !busy_prev)
            busy_cur <= 1;
        else if (bus.ocupado)
            busy_cur <= busy_cur + 1;
        if (!bus.ocupado && busy_prev)
            last_busy <= busy_cur;
        if (bus.erro_trigger)
            erro_cycles <= erro_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold trigger high for exactly n rising edges.
    task automatic pulse_trigger(input int n);
        @(posedge clk);
        #1 bus.trigger = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.trigger = 1'b0;
        drop_cyc = cyc;
    endtask

    task automatic wait_echo(input string tag);
        for (int i = 0; i < 100 && bus.echo !== 1'b1; i++)
            step(1);
        check(tag, bus.echo, 1);
    endtask

    task automatic measure(input logic [11:0] d, input int n, input int exp_w, input string tag);
        int p0;
        int e0;
        p0 = pulses;
        e0 = erro_cycles;
        bus.distancia = d;
        pulse_trigger(n);
        step(200);
        check({tag, "_pulses"}, pulses, p0 + 1);
        check({tag, "_width"}, last_w, exp_w);
        check({tag, "_latency"}, rise_cyc - drop_cyc, LATENCIA);
        check({tag, "_busy"}, last_busy, ECO_ATRASO + exp_w + RECUPERA);
        check({tag, "_estado"}, bus.db_estado, 0);
        check({tag, "_erro"}, erro_cycles, e0);
    endtask

    initial begin
        int p0;
        int e0;
        bus.habilita  = 1'b0;
        bus.trigger   = 1'b0;
        bus.distancia = 12'd0;

        // Reset values
        step(3);
        check("rst_echo", bus.echo, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_erro", bus.erro_trigger, 0);
        check("rst_estado", bus.db_estado, 0);
        rst_n = 1'b1;
        step(2);
        bus.habilita = 1'b1;

        // Normal measurements and width boundaries
        measure(12'd4, 6, 12, "d4");
        measure(12'd20, TRIG_MIN, 60, "trigmin_dmax");

        // Too-short trigger is rejected
        p0 = pulses;
        e0 = erro_cycles;
        bus.distancia = 12'd4;
        pulse_trigger(TRIG_MIN - 1);
        step(30);
        check("short_pulses", pulses, p0);
        check("short_erro_width", erro_cycles, e0 + 1);
        check("short_estado", bus.db_estado, 0);
        check("short_echo", bus.echo, 0);

        // Out-of-range distances give the timeout width
        measure(12'd0, 6, TIMEOUT, "d0");
        measure(12'd21, 6, TIMEOUT, "d21");
        measure(12'd1, 6, CLK_POR_MM, "d1");

        // Trigger and distance activity during the echo is ignored
        p0 = pulses;
        e0 = erro_cycles;
        bus.distancia = 12'd4;
        pulse_trigger(6);
        wait_echo("ign_rise");
        step(2);
        bus.distancia = 12'd9;
        pulse_trigger(6);
        step(200);
        check("ign_pulses", pulses, p0 + 1);
        check("ign_width", last_w, 12);
        check("ign_erro", erro_cycles, e0);

        // Asynchronous reset in the middle of the echo
        bus.distancia = 12'd4;
        pulse_trigger(6);
        wait_echo("rst_rise");
        step(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_echo", bus.echo, 0);
        check("midrst_estado", bus.db_estado, 0);
        check("midrst_ocupado", bus.ocupado, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
        measure(12'd4, 6, 12, "after_rst");

        // habilita low blocks acceptance; raising it with trigger still high measures
        p0 = pulses;
        bus.habilita = 1'b0;
        bus.distancia = 12'd4;
        @(posedge clk);
        #1 bus.trigger = 1'b1;
        step(10);
        check("dis_estado", bus.db_estado, 0);
        check("dis_ocupado", bus.ocupado, 0);
        check("dis_echo", bus.echo, 0);
        bus.habilita = 1'b1;
        step(6);
        bus.trigger = 1'b0;
        drop_cyc = cyc;
        step(200);
        check("en_pulses", pulses, p0 + 1);
        check("en_width", last_w, 12);
        check("en_latency", rise_cyc - drop_cyc, LATENCIA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
